// File: rtl/gpu_pkg.sv
// Shared state encodings for the SIMT core sequencer and the units it talks to.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_FETCH   = 3'd1,
    CS_DECODE  = 3'd2,
    CS_REQUEST = 3'd3,
    CS_WAIT    = 3'd4,
    CS_EXECUTE = 3'd5,
    CS_UPDATE  = 3'd6,
    CS_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'b000,
    FS_FETCHING = 3'b001,
    FS_FETCHED  = 3'b010
  } fetcher_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  // A lane's memory access is still outstanding while requesting or waiting.
  function automatic logic lsu_busy(input logic [1:0] state);
    case (state)
      LSU_REQUESTING: return 1'b1;
      LSU_WAITING:    return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/min_pc_select.sv
// Combinational tree reduction: smallest PC among live lanes and the mask of lanes sitting at it.
module min_pc_select
  import gpu_pkg::*;
#(
  parameter int T       = 4,
  parameter int PC_BITS = 8
) (
  input  logic [T*PC_BITS-1:0] i_thread_pc_n,
  input  logic [T-1:0]         i_live_n,
  output logic [PC_BITS-1:0]   o_m,
  output logic [T-1:0]         o_mask
);

  localparam int LEAVES = (T > 1) ? (1 << $clog2(T)) : 1;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [LEAVES*PC_BITS-1:0] w_pc_pad;
  logic [LEAVES-1:0]         w_live_pad;
  logic [PC_BITS-1:0]        w_node_pc  [NODES];
  logic                      w_node_vld [NODES];

  assign w_pc_pad   = (LEAVES*PC_BITS)'(i_thread_pc_n);
  assign w_live_pad = LEAVES'(i_live_n);

  // Heap-ordered tree: leaves at LEAVES-1.., node k merges children 2k+1 and 2k+2.
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      w_node_pc[k]  = {PC_BITS{1'b0}};
      w_node_vld[k] = 1'b0;
    end
    for (int i = 0; i < LEAVES; i++) begin
      w_node_pc[LEAVES-1+i]  = w_pc_pad[i*PC_BITS +: PC_BITS];
      w_node_vld[LEAVES-1+i] = w_live_pad[i];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (w_node_vld[2*k+1] && (!w_node_vld[2*k+2] || (w_node_pc[2*k+1] <= w_node_pc[2*k+2]))) begin
        w_node_pc[k]  = w_node_pc[2*k+1];
        w_node_vld[k] = 1'b1;
      end else begin
        w_node_pc[k]  = w_node_pc[2*k+2];
        w_node_vld[k] = w_node_vld[2*k+2];
      end
    end
  end

  // Every live lane at the minimum issues together, which is what reconverges them.
  always_comb begin
    o_mask = {T{1'b0}};
    if (w_node_vld[0]) begin
      o_m = w_node_pc[0];
    end else begin
      o_m = {PC_BITS{1'b0}};
    end
    for (int i = 0; i < T; i++) begin
      if (i_live_n[i] && (i_thread_pc_n[i*PC_BITS +: PC_BITS] == o_m)) begin
        o_mask[i] = 1'b1;
      end else begin
        o_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/simt_scheduler.sv
// Per-core control sequencer: steps one instruction at a time and issues the lowest PC among
// live threads, so divergent lanes serialise and reconverge without an explicit stack.
module simt_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]               thread_count,
  input  logic [2:0]                                       fetcher_state,
  input  logic                                             decoded_mem_read_enable,
  input  logic                                             decoded_mem_write_enable,
  input  logic                                             decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]                   lsu_state,
  input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [2:0]                                       core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                 current_pc,
  output logic [THREADS_PER_BLOCK-1:0]                     active_mask,
  output logic                                             diverged,
  output logic                                             done
);

  localparam int T   = THREADS_PER_BLOCK;
  localparam int PCB = PROGRAM_MEM_ADDR_BITS;
  localparam int TCW = $clog2(T) + 1;

  core_state_t          r_state;
  logic [PCB-1:0]       r_pc;
  logic [T-1:0]         r_mask;
  logic                 r_diverged;
  logic                 r_done;
  logic [T-1:0]         r_live;
  logic [T*PCB-1:0]     r_thread_pc;

  logic [TCW-1:0]       w_tc;
  logic [T-1:0]         w_launch_mask;
  logic                 w_lsu_busy;
  logic                 w_wait_hold;
  logic [T-1:0]         w_live_n;
  logic [T*PCB-1:0]     w_thread_pc_n;
  logic [PCB-1:0]       w_min_pc;
  logic [T-1:0]         w_min_mask;

  // Oversized thread counts clamp to the lane count; lanes below tc become live at launch.
  always_comb begin
    w_launch_mask = {T{1'b0}};
    if (thread_count > TCW'(T)) begin
      w_tc = TCW'(T);
    end else begin
      w_tc = thread_count;
    end
    for (int i = 0; i < T; i++) begin
      if (TCW'(i) < w_tc) begin
        w_launch_mask[i] = 1'b1;
      end else begin
        w_launch_mask[i] = 1'b0;
      end
    end
  end

  // Only active lanes of a memory instruction can hold the core in WAIT.
  always_comb begin
    w_lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (r_mask[i] && lsu_busy(lsu_state[2*i +: 2])) begin
        w_lsu_busy = 1'b1;
      end else begin
        w_lsu_busy = w_lsu_busy;
      end
    end
    w_wait_hold = w_lsu_busy && (decoded_mem_read_enable || decoded_mem_write_enable);
  end

  // Candidate lane state after this instruction retires (used only in UPDATE).
  always_comb begin
    w_thread_pc_n = r_thread_pc;
    if (decoded_ret) begin
      w_live_n = r_live & ~r_mask;
    end else begin
      w_live_n = r_live;
      for (int i = 0; i < T; i++) begin
        if (r_mask[i]) begin
          w_thread_pc_n[i*PCB +: PCB] = next_pc[i*PCB +: PCB];
        end else begin
          w_thread_pc_n[i*PCB +: PCB] = r_thread_pc[i*PCB +: PCB];
        end
      end
    end
  end

  min_pc_select #(
    .T       (T),
    .PC_BITS (PCB)
  ) u_min_pc_select (
    .i_thread_pc_n (w_thread_pc_n),
    .i_live_n      (w_live_n),
    .o_m           (w_min_pc),
    .o_mask        (w_min_mask)
  );

  // Core FSM with per-lane PC/live registers; all outputs come straight from these registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CS_IDLE;
      r_pc        <= {PCB{1'b0}};
      r_mask      <= {T{1'b0}};
      r_diverged  <= 1'b0;
      r_done      <= 1'b0;
      r_live      <= {T{1'b0}};
      r_thread_pc <= {(T*PCB){1'b0}};
    end else begin
      case (r_state)
        CS_IDLE: begin
          if (start) begin
            if (w_tc == {TCW{1'b0}}) begin
              r_state <= CS_DONE;
              r_done  <= 1'b1;
            end else begin
              r_live      <= w_launch_mask;
              r_mask      <= w_launch_mask;
              r_thread_pc <= {(T*PCB){1'b0}};
              r_pc        <= {PCB{1'b0}};
              r_diverged  <= 1'b0;
              r_state     <= CS_FETCH;
            end
          end
        end
        CS_FETCH: begin
          if (fetcher_state == FS_FETCHED) begin
            r_state <= CS_DECODE;
          end
        end
        CS_DECODE:  r_state <= CS_REQUEST;
        CS_REQUEST: r_state <= CS_WAIT;
        CS_WAIT: begin
          if (!w_wait_hold) begin
            r_state <= CS_EXECUTE;
          end
        end
        CS_EXECUTE: r_state <= CS_UPDATE;
        CS_UPDATE: begin
          r_live      <= w_live_n;
          r_thread_pc <= w_thread_pc_n;
          if (w_live_n == {T{1'b0}}) begin
            r_state    <= CS_DONE;
            r_done     <= 1'b1;
            r_mask     <= {T{1'b0}};
            r_diverged <= 1'b0;
          end else begin
            r_pc       <= w_min_pc;
            r_mask     <= w_min_mask;
            r_diverged <= (w_min_mask != w_live_n);
            r_state    <= CS_FETCH;
          end
        end
        CS_DONE: r_done <= 1'b1;
        default: r_state <= CS_IDLE;
      endcase
    end
  end

  assign core_state  = r_state;
  assign current_pc  = r_pc;
  assign active_mask = r_mask;
  assign diverged    = r_diverged;
  assign done        = r_done;

endmodule
